// File: rtl/hr_pkg.sv
// hr_pkg: shared defaults and FSM state encoding for the high-radix dot-product accumulator
package hr_pkg;

    localparam int PROD_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/hr_sat_adder.sv
// hr_sat_adder: ACC_W-bit adder with carry out; saturates on carry when HR_ACC_SAT_EN is defined, wraps otherwise
module hr_sat_adder #(
    parameter int ACC_W = 40
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] term,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W-1:0] raw;

    // Full-width add; the carry reports any excursion past 2^ACC_W-1
    always_comb begin
        {carry, raw} = {1'b0, acc} + {1'b0, term};
`ifdef HR_ACC_SAT_EN
        sum = carry ? '1 : raw;
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/hr_dot_accumulator.sv
// hr_dot_accumulator: accumulates len multiplier products over valid/ready into a wide sum (HR_ACC_SAT_EN selects saturation)
module hr_dot_accumulator
    import hr_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEFAULT,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             zero_pend;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic             fire;

    assign fire = prod_valid && prod_ready;

    // Zero-extend the unsigned product to accumulator width
    always_comb begin
        term = '0;
        term[PROD_W-1:0] = prod;
    end

    hr_sat_adder #(.ACC_W(ACC_W)) u_add (
        .acc   (acc_out),
        .term  (term),
        .sum   (sum),
        .carry (carry)
    );

    // Run FSM, term counter and registered status; a zero-length run waits one extra cycle in DONE before pulsing done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            zero_pend  <= 1'b0;
            acc_out    <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            prod_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (zero_pend) begin
                        done      <= 1'b1;
                        zero_pend <= 1'b0;
                    end
                    if (start) begin
                        acc_out    <= '0;
                        overflow   <= 1'b0;
                        remaining  <= len;
                        state      <= (len != '0) ? ST_ACCUM : ST_DONE;
                        zero_pend  <= (len == '0);
                        busy       <= (len != '0);
                        prod_ready <= (len != '0);
                    end
                end
                ST_ACCUM: begin
                    if (fire) begin
                        acc_out   <= sum;
                        overflow  <= overflow | carry;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            prod_ready <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hr_dot_accumulator.sv
// tb_hr_dot_accumulator: directed scoreboard bench for hr_dot_accumulator (honours HR_ACC_SAT_EN for the overflow run)
module tb_hr_dot_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  len = '0;
    logic        prod_valid = 1'b0;
    logic [31:0] prod = '0;
    logic        prod_ready;
    logic [39:0] acc_out;
    logic        busy;
    logic        done;
    logic        overflow;

    int checks = 0;
    int failures = 0;
    logic [40:0] exp_q[$];

`ifdef HR_ACC_SAT_EN
    localparam logic [39:0] OVF_FINAL = 40'hFF_FFFF_FFFF;
`else
    localparam logic [39:0] OVF_FINAL = 40'd188978560724;
`endif

    hr_dot_accumulator dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .prod_valid (prod_valid),
        .prod       (prod),
        .prod_ready (prod_ready),
        .acc_out    (acc_out),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [9:0] l, input logic [39:0] acc_exp, input logic ovf_exp);
        start = 1'b1;
        len = l;
        exp_q.push_back({ovf_exp, acc_exp});
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        logic hs;
        hs = 1'b0;
        prod_valid = 1'b1;
        prod = v;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = prod_ready;
            tick();
        end
        if (!hs) begin
            failures++;
            checks++;
            $display("FAIL send_timeout actual=0 required=1");
        end
    endtask

    task automatic idle(input int n);
        prod_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (reset && done) begin
                    if (exp_q.size() == 0) check("unexpected_done", 1, 0);
                    else begin
                        logic [40:0] e;
                        e = exp_q.pop_front();
                        check("sb_acc", acc_out, e[39:0]);
                        check("sb_ovf", overflow, e[40]);
                    end
                end
            end
        join_none

        #12;
        check("rst_acc", acc_out, 0);
        check("rst_flags", {prod_ready, busy, done, overflow}, 0);
        reset = 1'b1;
        tick();

        begin_run(10'd3, 40'd81409, 1'b0);
        check("basic_ready", prod_ready, 1);
        send(32'd65025);
        send(32'd16384);
        send(32'd0);
        check("basic_done", done, 1);
        check("basic_acc", acc_out, 81409);
        idle(1);
        check("basic_done_pulse", done, 0);

        begin_run(10'd0, 40'd0, 1'b0);
        check("zero_c1", {prod_ready, busy, done}, 0);
        tick();
        check("zero_c2_done", {prod_ready, done}, 1);
        check("zero_acc", acc_out, 0);
        tick();
        check("zero_c3_done", done, 0);

        begin_run(10'd4, 40'd5880, 1'b0);
        send(32'd125);
        idle(2);
        check("bp_busy1", busy, 1);
        send(32'd4096);
        idle(2);
        check("bp_acc_mid", acc_out, 4221);
        send(32'd1296);
        idle(2);
        check("bp_busy3", {busy, done}, 2);
        send(32'd363);
        check("bp_done", {busy, done}, 1);
        idle(2);

        begin_run(10'd300, OVF_FINAL, 1'b1);
        for (int i = 0; i < 256; i++) send(32'hFFFF_FFFF);
        check("ovf_256", overflow, 0);
        send(32'hFFFF_FFFF);
        check("ovf_257", overflow, 1);
        for (int i = 0; i < 43; i++) send(32'hFFFF_FFFF);
        check("ovf_final", acc_out, OVF_FINAL);
        idle(2);
        check("ovf_hold", {overflow, acc_out}, {1'b1, OVF_FINAL});

        start = 1'b1;
        len = 10'd5;
        tick();
        start = 1'b0;
        send(32'd11);
        send(32'd22);
        #2;
        reset = 1'b0;
        #1;
        check("arst_acc", acc_out, 0);
        check("arst_flags", {prod_ready, busy, done, overflow}, 0);
        prod_valid = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        tick();
        idle(3);
        begin_run(10'd1, 40'd800, 1'b0);
        send(32'd800);
        check("post_rst_acc", acc_out, 800);
        idle(2);

        begin_run(10'd3, 40'd60, 1'b0);
        send(32'd10);
        start = 1'b1;
        len = 10'd7;
        send(32'd20);
        start = 1'b0;
        check("ign_start_busy", busy, 1);
        send(32'd30);
        check("ign_start_done", {busy, done}, 1);
        begin_run(10'd2, 40'd15, 1'b0);
        check("b2b_clear", {busy, acc_out}, {1'b1, 40'd0});
        send(32'd7);
        send(32'd8);
        idle(3);

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hr_dot_accumulator.md
Name: hr_dot_accumulator

Overview:
- Downstream consumer of the high-radix 16x16 multiplier.
- Takes its 32-bit products over a valid/ready handshake and accumulates a programmed number of them into a wide dot-product sum.
- Reports done, busy and overflow status.
- Sits between the multiplier output and the result/readback logic.

Parameters:
- PROD_W, 32, product width; matches the multiplier output.
- ACC_W, 40, accumulator width; must be >= PROD_W.
- LEN_W, 10, width of the term-count field; max length is 2^LEN_W-1.

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a new accumulation. Honoured only in IDLE or DONE.
- len  input  LEN_W  number of products to accumulate; sampled on start.
- prod_valid  input  1  product on prod is valid.
- prod  input  PROD_W  unsigned product from the multiplier.
- prod_ready  output  1  block accepts prod this cycle.
- acc_out  output  ACC_W  accumulated sum.
- busy  output  1  high while in ACCUM.
- done  output  1  one-cycle pulse when the sum is complete.
- overflow  output  1  sticky; the sum exceeded 2^ACC_W-1 during this run.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - acc_out=0, remaining count=0.
  - prod_ready=0, busy=0, done=0, overflow=0.
- Reset mid-ACCUM aborts the run with no done pulse.
- States: IDLE, ACCUM, DONE.
- IDLE and DONE, on start:
  - Clear acc_out and overflow; latch len into the remaining counter.
  - If len != 0, go to ACCUM.
  - If len == 0, go to DONE and pulse done the next cycle with acc_out=0.
- ACCUM:
  - prod_ready=1 and busy=1.
  - Handshake occurs when prod_valid && prod_ready. On a handshake, acc_out += zero-extended prod and remaining decrements.
  - A handshake that brings remaining to 0 moves the state to DONE.
  - done is high exactly one cycle, in the cycle after the last handshake; acc_out is final in that same cycle.
  - start is ignored in ACCUM.
- DONE:
  - acc_out and overflow hold until the next start or reset.
  - done is a registered pulse, cleared after one cycle.
  - start in the same cycle that done is high is legal and restarts the run.
- prod_ready is a registered state decode; it does not combinationally depend on prod_valid.
- Addition overflow behaviour is set by HR_ACC_SAT_EN (see Optional Feature). In both modes overflow sets on the first carry out of ACC_W and stays set until the next start.
- Throughput: one product per cycle while prod_valid stays high.

Optional Feature:
- Macro: HR_ACC_SAT_EN.
- Defined: on carry out, acc_out saturates to 2^ACC_W-1 and stays there for the remaining terms.
- Undefined: acc_out wraps modulo 2^ACC_W.
- The overflow flag behaves identically in both builds.

Decomposition:
- Shared package hr_pkg holds:
  - PROD_W default.
  - State encoding constants: ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2.
- One natural sub-module: hr_sat_adder.
  - Combinational ACC_W adder.
  - Takes an accumulator value and a zero-extended product.
  - Produces the sum and a carry flag, with saturation compiled under HR_ACC_SAT_EN.
- The FSM and counter stay in the top module.

Test Plan:
- Basic sum: start, len=3, products 65025, 16384, 0 with prod_valid held high.
  - Three consecutive handshakes; done pulses one cycle after the third.
  - acc_out=81409, overflow=0.
- Zero length: start, len=0.
  - prod_ready never asserts; done pulses two cycles after start; acc_out=0.
- Backpressure gaps: len=4, products 125, 4096, 1296, 363, with prod_valid low for 2 cycles between each.
  - Only valid cycles count; acc_out=5880; busy stays high until done.
- Overflow: len=300, every product 32'hFFFFFFFF.
  - overflow sets on the 257th handshake.
  - With HR_ACC_SAT_EN: final acc_out=40'hFFFFFFFFFF.
  - Without it: final acc_out=188978560724.
- Reset mid-run: len=5, assert reset after 2 handshakes.
  - All outputs are 0 immediately (asynchronous); no done pulse.
  - A following start with len=1 and prod=800 yields acc_out=800.
- Start during ACCUM is ignored, and back-to-back runs work.
  - A second start pulse during ACCUM leaves the counter and sum unchanged.
  - A start issued in the done cycle clears acc_out and begins a new run.
